// File: rtl/spi_slave_sequencer.sv
// SPI slave front end: pin sync, sck strobes, command decode, target routing.
// Optional status echo on MISO during the command byte: SPI_SEQ_STATUS_ECHO_EN.
module spi_slave_sequencer #(
    parameter int NT          = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          spi_sck,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          rising,
    output logic          falling,
    output logic          si,
    output logic          reset_flag,
    output logic [NT-1:0] sel,
    input  logic [NT-1:0] target_so,
    output logic [7:0]    cmd,
    output logic          cmd_valid,
    output logic          cmd_error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_DATA,
        S_DISCARD
    } state_t;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES:0]   r_live;
    logic                   r_armed;

    state_t                 r_state;
    logic [3:0]             r_bitcnt;
    logic [7:0]             r_shift;
    logic                   r_miso;
    logic                   r_rising;
    logic                   r_falling;
    logic                   r_si;
    logic                   r_reset_flag;
    logic [NT-1:0]          r_sel;
    logic [7:0]             r_cmd;
    logic                   r_cmd_valid;
    logic                   r_cmd_error;

    logic                   w_sck;
    logic                   w_cs;
    logic                   w_mosi;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;
    logic [3:0]             w_idx;
    logic                   w_idx_ok;
    logic [NT-1:0]          w_onehot;
    logic                   w_so;

`ifdef SPI_SEQ_STATUS_ECHO_EN
    localparam logic [3:0] LP_NT_M1 = 4'(NT - 1);
    logic [7:0] r_echo;
    logic [7:0] w_status;
    assign w_status = {r_cmd_error, 3'b000, LP_NT_M1};
`endif

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs       = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_sck_fall = ~w_sck & r_sck_d;
    assign w_cs_rise  = w_cs & ~r_cs_d;
    // A frame only starts after cs_n has been seen high since reset.
    assign w_cs_fall  = r_armed & ~w_cs & r_cs_d;

    assign w_idx    = r_shift[7:4];
    assign w_idx_ok = int'(w_idx) < NT;
    assign w_so     = |(target_so & r_sel);

    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NT; i++) begin
            if (w_idx == i[3:0]) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b1;
            r_live      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            r_sck_d     <= w_sck;
            r_cs_d      <= w_cs;
            r_live      <= {r_live[SYNC_STAGES-1:0], 1'b1};
            if (r_live[SYNC_STAGES] && w_cs && r_state == S_IDLE) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_miso       <= 1'b0;
            r_rising     <= 1'b0;
            r_falling    <= 1'b0;
            r_si         <= 1'b0;
            r_reset_flag <= 1'b0;
            r_sel        <= '0;
            r_cmd        <= 8'h00;
            r_cmd_valid  <= 1'b0;
            r_cmd_error  <= 1'b0;
`ifdef SPI_SEQ_STATUS_ECHO_EN
            r_echo       <= '0;
`endif
        end else begin
            r_rising     <= 1'b0;
            r_falling    <= 1'b0;
            r_reset_flag <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_si         <= w_mosi;

            if (w_cs_fall) begin
                r_reset_flag <= 1'b1;
                r_bitcnt     <= '0;
                r_shift      <= '0;
                r_sel        <= '0;
                r_state      <= S_CMD;
`ifdef SPI_SEQ_STATUS_ECHO_EN
                r_echo       <= w_status;
                r_miso       <= w_status[7];
`else
                r_miso       <= 1'b0;
`endif
            end else if (w_cs_rise) begin
                // Frame end beats any sck edge seen in the same cycle.
                r_state  <= S_IDLE;
                r_sel    <= '0;
                r_miso   <= 1'b0;
                r_bitcnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_rising  <= w_sck_rise;
                r_falling <= w_sck_fall;
                unique case (r_state)
                    S_CMD: begin
                        // Decode one cycle after the 8th strobe is broadcast,
                        // so no target ever sees a command bit while selected.
                        if (r_bitcnt == 4'd8) begin
                            r_cmd       <= r_shift;
                            r_cmd_valid <= 1'b1;
                            r_miso      <= 1'b0;
                            if (w_idx_ok) begin
                                r_sel   <= w_onehot;
                                r_state <= S_DATA;
                            end else begin
                                r_cmd_error <= 1'b1;
                                r_state     <= S_DISCARD;
                            end
                        end else if (w_sck_rise) begin
                            r_shift  <= {r_shift[6:0], w_mosi};
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
`ifdef SPI_SEQ_STATUS_ECHO_EN
                        else if (r_falling) begin
                            r_echo <= {r_echo[6:0], 1'b0};
                            r_miso <= r_echo[6];
                        end
`endif
                    end
                    S_DATA: begin
                        // Capture before the target shifts on this strobe.
                        if (r_falling) begin
                            r_miso <= w_so;
                        end
                    end
                    S_DISCARD: begin
                        r_sel  <= '0;
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_sel <= '0;
                    end
                endcase
            end
        end
    end

    assign spi_miso   = r_miso;
    assign rising     = r_rising;
    assign falling    = r_falling;
    assign si         = r_si;
    assign reset_flag = r_reset_flag;
    assign sel        = r_sel;
    assign cmd        = r_cmd;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_error  = r_cmd_error;

endmodule

// File: tb/tb_spi_slave_sequencer.sv
// Directed and randomized frames for spi_slave_sequencer, checked against
// a frame-level model of the expected MOSI/MISO bit streams and strobes.
module tb_spi_slave_sequencer;

    localparam int NT   = 4;
    localparam int SS   = 2;
    localparam int HALF = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_sck = 1'b0;
    logic          spi_cs_n = 1'b1;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          rising;
    logic          falling;
    logic          si;
    logic          reset_flag;
    logic [NT-1:0] sel;
    logic [NT-1:0] target_so;
    logic [7:0]    cmd;
    logic          cmd_valid;
    logic          cmd_error;

    always #5 clk = ~clk;

    spi_slave_sequencer #(.NT(NT), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi_sck    (spi_sck),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rising     (rising),
        .falling    (falling),
        .si         (si),
        .reset_flag (reset_flag),
        .sel        (sel),
        .target_so  (target_so),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .cmd_error  (cmd_error)
    );

    // Target environment: each loads a word at frame start and shifts
    // it out MSB first on falling strobes while selected.
    logic [15:0] tword [NT];
    logic [15:0] tsr   [NT];

    always @(posedge clk) begin
        for (int i = 0; i < NT; i++) begin
            if (!reset_n) tsr[i] <= 16'h0;
            else if (reset_flag) tsr[i] <= tword[i];
            else if (falling && sel[i]) tsr[i] <= {tsr[i][14:0], 1'b0};
        end
    end

    for (genvar g = 0; g < NT; g++) begin : g_so
        assign target_so[g] = tsr[g][15];
    end

    int          n_rise, n_fall, n_rf, n_cv;
    logic [63:0] miso_log, si_log;
    logic [NT-1:0] sel_at_cv;

    always @(negedge clk) begin
        if (rising) begin
            n_rise++;
            miso_log = {miso_log[62:0], spi_miso};
            si_log   = {si_log[62:0], si};
        end
        if (falling) n_fall++;
        if (reset_flag) n_rf++;
        if (cmd_valid) begin
            n_cv++;
            sel_at_cv = sel;
        end
    end

    int       tests = 0;
    int       fails = 0;
    logic [7:0] m_cmd;
    logic       m_err;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_mon();
        n_rise = 0; n_fall = 0; n_rf = 0; n_cv = 0;
        miso_log = '0; si_log = '0; sel_at_cv = '0;
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        tick(HALF);
        spi_sck = 1'b1;
        tick(HALF);
        spi_sck = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] c, input int nbits,
                             input logic [31:0] dat, input bit align);
        logic [63:0] exp_miso, exp_si;
        logic [7:0]  st;
        logic [NT-1:0] es;
        logic        b, mb;
        int          idx, nr, lat;
`ifdef SPI_SEQ_STATUS_ECHO_EN
        st = {m_err, 3'b000, 4'(NT - 1)};
`else
        st = 8'h00;
`endif
        idx = int'(c[7:4]);
        nr  = align ? nbits - 1 : nbits;
        exp_miso = '0;
        exp_si   = '0;
        for (int k = 0; k < nr; k++) begin
            b = (k < 8) ? c[7-k] : dat[k-8];
            if (k < 8) mb = st[7-k];
            else if (idx < NT && k - 8 < 16) mb = tword[idx][15-(k-8)];
            else mb = 1'b0;
            exp_si   = {exp_si[62:0], b};
            exp_miso = {exp_miso[62:0], mb};
        end

        clr_mon();
        spi_cs_n = 1'b0;
        tick(HALF);
        for (int k = 0; k < nbits; k++) begin
            b = (k < 8) ? c[7-k] : dat[k-8];
            if (align && k == nbits - 1) begin
                spi_mosi = b;
                tick(HALF);
                spi_sck  = 1'b1;
                spi_cs_n = 1'b1;
                tick(HALF);
                spi_sck  = 1'b0;
            end else begin
                send_bit(b);
            end
        end
        if (!align) begin
            tick(HALF);
            spi_cs_n = 1'b1;
            lat = 0;
            for (int t = 1; t <= 12; t++) begin
                tick(1);
                lat = t;
                if (sel == '0) break;
            end
            chk("sel_drop_in_time", 64'(lat <= SS + 2), 64'd1);
        end
        tick(2 * HALF + 4);

        chk("reset_flag_cycles", 64'(n_rf), 64'd1);
        chk("rise_count", 64'(n_rise), 64'(nr));
        chk("fall_count", 64'(n_fall), 64'(align ? nbits - 1 : nbits));
        chk("si_stream", si_log, exp_si);
        chk("miso_stream", miso_log, exp_miso);
        if (nbits >= 8) begin
            m_cmd = c;
            if (idx >= NT) m_err = 1'b1;
            es = '0;
            if (idx < NT) es[idx] = 1'b1;
            chk("cmd_valid_cycles", 64'(n_cv), 64'd1);
            chk("sel_at_cmd_valid", 64'(sel_at_cv), 64'(es));
        end else begin
            chk("cmd_valid_none", 64'(n_cv), 64'd0);
        end
        chk("cmd", 64'(cmd), 64'(m_cmd));
        chk("cmd_error", 64'(cmd_error), 64'(m_err));
        chk("sel_idle", 64'(sel), 64'd0);
    endtask

    initial begin
        logic [7:0] c;
        int nb;
        bit al;

        for (int i = 0; i < NT; i++) tword[i] = 16'($urandom);
        m_cmd = 8'h00;
        m_err = 1'b0;
        clr_mon();
        tick(3);
        chk("outs_in_reset",
            {rising, falling, reset_flag, 4'(sel), cmd, cmd_valid,
             cmd_error, spi_miso, si}, 64'd0);
        reset_n = 1'b1;
        tick(6);
        chk("outs_after_reset",
            {rising, falling, reset_flag, 4'(sel), cmd, cmd_valid,
             cmd_error, spi_miso, si}, 64'd0);
        chk("no_strobes_idle", 64'(n_rise + n_fall + n_rf + n_cv), 64'd0);

        run_frame(8'h10, 8, 32'h0, 1'b0);

        tword[0] = 16'hA55A;
        run_frame(8'h00, 24, $urandom, 1'b0);

        run_frame(8'h50, 14, $urandom, 1'b0);
        run_frame(8'h2C, 12, $urandom, 1'b0);

        run_frame(8'hA5, 5, 32'h0, 1'b0);
        run_frame(8'h30, 10, $urandom, 1'b0);

        run_frame(8'h10, 13, $urandom, 1'b1);

        // Reset in the middle of a frame: rest of that frame is ignored.
        spi_cs_n = 1'b0;
        tick(HALF);
        for (int k = 0; k < 3; k++) send_bit(1'($urandom));
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        m_cmd = 8'h00;
        m_err = 1'b0;
        clr_mon();
        for (int k = 0; k < 6; k++) send_bit(1'($urandom));
        tick(HALF);
        chk("midreset_strobes", 64'(n_rise + n_fall + n_rf + n_cv), 64'd0);
        chk("midreset_cmd", 64'(cmd), 64'd0);
        chk("midreset_err", 64'(cmd_error), 64'd0);
        chk("midreset_sel", 64'(sel), 64'd0);
        spi_cs_n = 1'b1;
        tick(10);

        run_frame(8'h20, 20, $urandom, 1'b0);

        for (int f = 0; f < 14; f++) begin
            for (int i = 0; i < NT; i++) tword[i] = 16'($urandom);
            c  = {4'($urandom_range(0, 5)), 4'($urandom)};
            nb = 8 + int'($urandom_range(0, 22));
            al = ($urandom_range(0, 3) == 0) && (nb > 9);
            run_frame(c, nb, $urandom, al);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_slave_sequencer.md
Name: spi_slave_sequencer

Overview:
- Front-end controller for the DSO SPI slave port.
- Synchronises the raw SPI pins into the clk domain and produces one-cycle sck edge strobes.
- Decodes an 8-bit command byte at the start of every chip-select frame, then routes the remaining bits of the frame to exactly one downstream shift-based target (memory writer, memory reader, register bank, ...).
- Owns the per-frame reset_flag pulse, the one-hot target select, and the MISO return mux.

Parameters:
- NT, 4: number of downstream targets (1..16).
- SYNC_STAGES, 2: synchroniser flops on spi_sck, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- spi_sck  in  1  raw SPI clock, mode 0 (idle low, sample on rising edge).
- spi_cs_n  in  1  raw SPI chip select, active low.
- spi_mosi  in  1  raw SPI data in.
- spi_miso  out  1  SPI data out.
- rising  out  1  one-cycle strobe on synchronised sck rising edge; broadcast to all targets.
- falling  out  1  one-cycle strobe on synchronised sck falling edge; broadcast.
- si  out  1  synchronised mosi; broadcast.
- reset_flag  out  1  one-cycle pulse at frame start; broadcast.
- sel  out  NT  one-hot target select.
- target_so  in  NT  serial outputs of the targets.
- cmd  out  8  last accepted command byte.
- cmd_valid  out  1  one-cycle strobe when cmd is updated.
- cmd_error  out  1  sticky flag: a command addressed a target index >= NT.

Behaviour:
- Reset values: all outputs 0; cmd = 8'h00; state IDLE; bit counter 0.
- Synchroniser:
  - sck, cs_n and mosi each pass through SYNC_STAGES flops; cs_n flops reset to 1.
  - Edge detection compares the last sync stage with one extra delay flop.
  - Strobe latency from pin to strobe is SYNC_STAGES+1 clk cycles.
- Timing constraint: the SCK high time and low time must each be at least SYNC_STAGES+2 clk cycles. Faster SCK is out of spec.
- FSM states: IDLE, CMD, DATA, DISCARD.
- IDLE:
  - Synced cs_n falls: assert reset_flag for exactly one cycle, clear bit counter and command shift register, go to CMD.
- CMD:
  - Each rising strobe shifts si into the command shift register, MSB first, and increments the bit counter.
  - On the 8th rising strobe:
    - cmd is loaded and cmd_valid pulses in the following cycle.
    - The target index is cmd[7:4].
    - If the index is < NT: sel[index] = 1 in that same following cycle, go to DATA.
    - Otherwise: set cmd_error, go to DISCARD.
  - cmd[3:0] is reserved and ignored by this block.
- DATA:
  - sel is held.
  - spi_miso = target_so[index], registered; it updates in the cycle after each falling strobe and otherwise holds its value.
  - The bit count is not limited; targets handle their own word boundaries.
- DISCARD:
  - All sel = 0; spi_miso = 0; strobes still broadcast.
- Frame end:
  - Synced cs_n rising edge in any state: go to IDLE and clear sel in the same cycle the edge is detected.
  - cmd is retained.
- Simultaneous events:
  - If a cs_n rise and an sck strobe fall in the same cycle, the cs_n rise wins. The sck strobe is suppressed: rising and falling outputs stay 0 and nothing is shifted.
  - A cs_n fall detected while not in IDLE (glitch) restarts the frame: reset_flag pulses, go to CMD.
- Strobes outside a frame:
  - Strobes are gated off while in IDLE; rising, falling and reset_flag are never asserted in IDLE.
- Asynchronous reset mid-frame:
  - Returns to IDLE immediately.
  - The remainder of the frame is ignored until cs_n goes high and then low again.
- cmd_error is cleared only by reset.

Optional Feature:
- Macro: SPI_SEQ_STATUS_ECHO_EN.
- Defined:
  - During CMD, spi_miso shifts out the status byte {cmd_error, 3'b000, NT-1 as a 4-bit value}, MSB first.
  - Bit 7 is presented immediately on entry to CMD; each subsequent bit follows a falling strobe.
- Undefined:
  - spi_miso = 0 throughout CMD.

Test Plan:
- Reset, then cs_n low and command 8'h10 with NT=4 -> reset_flag pulses once; after the 8th rising strobe, cmd=8'h10, cmd_valid pulses once, sel=4'b0010.
- Frame with command 8'h00 followed by 16 data bits, with target_so[0] driven by a model returning 16'hA55A -> spi_miso carries A55A bit-serially; rising strobe count = 24; sel[0] drops within SYNC_STAGES+2 cycles of cs_n rising.
- Command 8'h50 with NT=4 -> sel stays 0, cmd_error=1, spi_miso=0 for the rest of the frame; the next valid frame still works and cmd_error remains 1.
- cs_n raised after 5 command bits -> no cmd_valid, sel=0, state IDLE; the next frame decodes a fresh 8 bits correctly.
- cs_n rise aligned to the same cycle as a rising strobe -> that rising strobe is not forwarded and sel is cleared.
- With SPI_SEQ_STATUS_ECHO_EN, NT=4, cmd_error=0 -> the first 8 MISO bits of the frame are 8'h03; without the macro they are 8'h00.
